// File: rtl/c_chan_pkg.sv
// c_chan_pkg
//   Shared types and helpers for the clocked-to-self-timed channel arbiter.
//   - cc_state_t : handshake sequencer states
//   - rr_pick    : round-robin selection, first valid index after a pointer
package c_chan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    ERR  = 2'd3
  } cc_state_t;

  // Widest requester vector rr_pick can accept; callers zero-extend into it.
  localparam int RR_MAX = 32;

  // Returns the first index i with valid[i]=1, searching ptr+1, ptr+2, ...
  // modulo n. Walking the distance downwards lets the nearest hit land last
  // and win. With nothing valid the pointer itself is returned; callers
  // only use the result when at least one bit is set.
  function automatic int rr_pick(input logic [RR_MAX-1:0] valid,
                                 input int ptr,
                                 input int n);
    int idx;
    rr_pick = ptr;
    for (int k = n; k >= 1; k--) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (valid[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/c_chan_arbiter_bit_sync.sv
// bit_sync
//   Flop-chain synchronizer for a single asynchronous level.
//   Ports:
//     clk   in  system clock
//     rst_n in  asynchronous active-low reset, clears every stage to 0
//     d     in  asynchronous input
//     q     out synchronized level, STAGES clocks behind d
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/c_chan_arbiter.sv
// c_chan_arbiter
//   Round-robin arbiter feeding one four-phase (return-to-zero) asynchronous
//   channel from N_REQ synchronous requesters. The grantee's word is latched
//   onto ch_data and ch_req is raised; the returning ch_ack is synchronized
//   and the sequencer walks IDLE -> RISE -> FALL -> IDLE, or into ERR when an
//   ack edge fails to arrive within TIMEOUT cycles.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     req_valid    per-requester word pending
//     req_data     requester i word at [i*DATA_W +: DATA_W]
//     req_done     one-cycle pulse when requester i's transfer ends or drops
//     ch_req       four-phase request to the channel
//     ch_data      bundled data, held from grant until the handshake closes
//     ch_ack       asynchronous acknowledge from the C-element stage
//     busy         sequencer not in IDLE
//     grant_id     current / most recent grantee
//     timeout_err  one-cycle pulse when an ack edge timed out
module c_chan_arbiter
  import c_chan_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_done,
  output logic                      ch_req,
  output logic [DATA_W-1:0]         ch_data,
  input  logic                      ch_ack,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      timeout_err
);

  localparam int GID_W = $clog2(N_REQ);
  // Wide enough to hold TIMEOUT-1; stays at least one bit when TIMEOUT is 0.
  localparam int CNT_W = $clog2(TIMEOUT + 2);

  cc_state_t          state_reg,       state_next;
  logic               ch_req_reg,      ch_req_next;
  logic [DATA_W-1:0]  ch_data_reg,     ch_data_next;
  logic [GID_W-1:0]   grant_reg,       grant_next;
  logic [GID_W-1:0]   ptr_reg,         ptr_next;
  logic [CNT_W-1:0]   cnt_reg,         cnt_next;
  logic [N_REQ-1:0]   done_reg,        done_next;
  logic               timeout_err_reg, timeout_err_next;

  logic               ack_s;
  logic [RR_MAX-1:0]  valid_ext;
  logic [GID_W-1:0]   pick_idx;
  logic               timeout_hit;

  bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ch_ack),
    .q     (ack_s)
  );

  always_comb begin
    valid_ext                = '0;
    valid_ext[N_REQ-1:0]     = req_valid;
    pick_idx                 = GID_W'(rr_pick(valid_ext, int'(ptr_reg), N_REQ));
  end

  // Fires on the last permitted waiting cycle. It is checked only after the
  // awaited ack edge, so an edge arriving in the same cycle takes priority.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_next       = state_reg;
    ch_req_next      = ch_req_reg;
    ch_data_next     = ch_data_reg;
    grant_next       = grant_reg;
    ptr_next         = ptr_reg;
    cnt_next         = '0;
    done_next        = '0;
    timeout_err_next = 1'b0;

    case (state_reg)
      IDLE: begin
        ch_req_next = 1'b0;
        // A high ack_s here is a leftover from an interrupted handshake;
        // granting now would let that stale level close the new transfer.
        if ((|req_valid) && !ack_s) begin
          grant_next   = pick_idx;
          ptr_next     = pick_idx;
          ch_data_next = req_data[pick_idx*DATA_W +: DATA_W];
          ch_req_next  = 1'b1;
          state_next   = RISE;
        end
      end

      RISE: begin
        if (ack_s) begin
          ch_req_next = 1'b0;
          state_next  = FALL;
        end else if (timeout_hit) begin
          ch_req_next           = 1'b0;
          timeout_err_next      = 1'b1;
          done_next[grant_reg]  = 1'b1;
          state_next            = ERR;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      FALL: begin
        if (!ack_s) begin
          done_next[grant_reg] = 1'b1;
          state_next           = IDLE;
        end else if (timeout_hit) begin
          ch_req_next           = 1'b0;
          timeout_err_next      = 1'b1;
          done_next[grant_reg]  = 1'b1;
          state_next            = ERR;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      ERR: begin
        // Let the channel return to zero before anyone is granted again.
        ch_req_next = 1'b0;
        if (!ack_s) state_next = IDLE;
      end

      default: begin
        ch_req_next = 1'b0;
        state_next  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      ch_req_reg      <= 1'b0;
      ch_data_reg     <= '0;
      grant_reg       <= '0;
      ptr_reg         <= GID_W'(N_REQ - 1);
      cnt_reg         <= '0;
      done_reg        <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ch_req_reg      <= ch_req_next;
      ch_data_reg     <= ch_data_next;
      grant_reg       <= grant_next;
      ptr_reg         <= ptr_next;
      cnt_reg         <= cnt_next;
      done_reg        <= done_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign ch_req      = ch_req_reg;
  assign ch_data     = ch_data_reg;
  assign grant_id    = grant_reg;
  assign req_done    = done_reg;
  assign timeout_err = timeout_err_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_c_chan_arbiter.sv
// Testbench for c_chan_arbiter: requesters hold word queues, a reference
// model derives the grant order from round-robin rules, and a monitor pops
// expected transfers as the DUT raises ch_req and pulses req_done.
module tb_c_chan_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_done;
  logic           ch_req;
  logic [W-1:0]   ch_data;
  logic           ch_ack;
  logic           busy;
  logic [1:0]     grant_id;
  logic           timeout_err;

  always #5 clk = ~clk;

  c_chan_arbiter #(
    .N_REQ(N), .DATA_W(W), .SYNC_STAGES(SS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_done(req_done), .ch_req(ch_req), .ch_data(ch_data), .ch_ack(ch_ack),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  // Channel: 0 = C-element with 3..20 delay, 1 = stuck high, 2 = stuck low,
  // 3 = driven directly by the stimulus.
  int   ack_mode = 0;
  logic ack_model = 1'b0;
  logic ctrl_ack = 1'b0;
  assign ch_ack = (ack_mode == 0) ? ack_model :
                  (ack_mode == 1) ? 1'b1 :
                  (ack_mode == 2) ? 1'b0 : ctrl_ack;

  initial begin
    int d;
    forever begin
      wait (ack_model != ch_req);
      d = $urandom_range(3, 20);
      #d;
      ack_model = ch_req;
    end
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    int       id;
    logic [W-1:0] data;
    bit       tmo;
  } exp_t;

  exp_t exp_q[$];
  int   drv_q[$];
  logic [W-1:0] wbuf[N][4];
  int   whead[N];
  int   wcnt[N];
  int   model_ptr = N - 1;
  bit   mon_active = 1'b0;
  bit   drv_prev = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=no-event", name);
  endtask

  task automatic add_word(input int i, input logic [W-1:0] d);
    wbuf[i][(whead[i] + wcnt[i]) % 4] = d;
    wcnt[i]++;
  endtask

  // Reference model: pending words are served first-valid-after-last-grant;
  // a requester's next word becomes visible right after its grant.
  task automatic load_batch(input bit tmo);
    int   hd[N];
    int   cn[N];
    int   total;
    int   idx;
    exp_t e;
    total = 0;
    for (int i = 0; i < N; i++) begin
      hd[i] = whead[i];
      cn[i] = wcnt[i];
      total += cn[i];
    end
    while (total > 0) begin
      for (int k = 1; k <= N; k++) begin
        idx = (model_ptr + k) % N;
        if (cn[idx] > 0) begin
          e.id   = idx;
          e.data = wbuf[idx][hd[idx]];
          e.tmo  = tmo;
          exp_q.push_back(e);
          drv_q.push_back(idx);
          hd[idx] = (hd[idx] + 1) % 4;
          cn[idx]--;
          total--;
          model_ptr = idx;
          break;
        end
      end
    end
  endtask

  task automatic flush();
    exp_q.delete();
    drv_q.delete();
    for (int i = 0; i < N; i++) begin
      whead[i] = 0;
      wcnt[i]  = 0;
    end
    model_ptr = N - 1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (wcnt[i] > 0);
      req_data[i*W +: W] = (wcnt[i] > 0) ? wbuf[i][whead[i]] : '0;
    end
  endtask

  function automatic bit words_pending();
    words_pending = 1'b0;
    for (int i = 0; i < N; i++) if (wcnt[i] > 0) words_pending = 1'b1;
  endfunction

  // One clock: sample 2 units after the edge, retire the granted word, redrive.
  task automatic step();
    int id;
    @(posedge clk);
    #2;
    if (!rst_n) begin
      drv_prev = 1'b0;
    end else begin
      if (ch_req && !drv_prev && drv_q.size() > 0) begin
        id = drv_q.pop_front();
        if (wcnt[id] > 0) begin
          whead[id] = (whead[id] + 1) % 4;
          wcnt[id]--;
        end
      end
      drv_prev = ch_req;
    end
    drive();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active || busy || words_pending()) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) fail("drain_timeout");
  endtask

  // Monitor: pops one expected transfer per ch_req rise, checks it to done.
  initial begin
    exp_t cur;
    int   hi;
    bit   mon_prev;
    hi = 0;
    mon_prev = 1'b0;
    cur.id = 0; cur.data = '0; cur.tmo = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mon_active = 1'b0;
        mon_prev   = 1'b0;
        hi         = 0;
      end else begin
        chk("done_onehot0", longint'($onehot0(req_done)), 1);
        if (ch_req && !mon_prev) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_grant");
          end else begin
            cur = exp_q.pop_front();
            mon_active = 1'b1;
            hi = 0;
            chk("grant_id", grant_id, cur.id);
            chk("grant_data", ch_data, cur.data);
          end
        end
        if (ch_req) hi++;
        if (mon_active && busy) chk("data_hold", ch_data, cur.data);
        if (req_done != '0) begin
          if (!mon_active) begin
            chk("spurious_done", req_done, 0);
          end else begin
            chk("done_bit", req_done, longint'(1) << cur.id);
            chk("timeout_err", timeout_err, cur.tmo);
            chk("busy_at_done", busy, cur.tmo);
            chk("ch_req_at_done", ch_req, 0);
            if (cur.tmo) chk("timeout_cycles", hi, TO);
            $display("xfer id=%0d data=%02h timeout=%0b", cur.id, cur.data, cur.tmo);
            mon_active = 1'b0;
          end
        end else if (timeout_err) begin
          chk("timeout_without_done", timeout_err, 0);
        end
        mon_prev = ch_req;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    flush();
    drive();
    repeat (3) step();
    chk("rst_ch_req", ch_req, 0);
    chk("rst_ch_data", ch_data, 0);
    chk("rst_req_done", req_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Basic transfer: registered grant shows ch_req one cycle later.
    add_word(0, 8'hA5);
    load_batch(1'b0);
    drive();
    n = 0;
    while (!ch_req && n < 10) begin step(); n++; end
    chk("basic_latency", n, 1);
    drain(200);

    // Timeout with ack stuck low.
    ack_mode = 2;
    add_word(0, W'($urandom));
    load_batch(1'b1);
    drive();
    drain(100);

    // Ack edge reaches ack_s on the same cycle the timeout would expire.
    ack_mode = 3;
    ctrl_ack = 1'b0;
    add_word(2, W'($urandom));
    load_batch(1'b0);
    drive();
    n = 0;
    while (!ch_req && n < 20) begin step(); n++; end
    if (!ch_req) fail("coincide_no_grant");
    repeat (TO - SS - 1) step();
    ctrl_ack = 1'b1;
    repeat (SS + 1) step();
    chk("coincide_ch_req", ch_req, 0);
    chk("coincide_timeout_err", timeout_err, 0);
    chk("coincide_busy", busy, 1);
    ctrl_ack = 1'b0;
    drain(100);
    ack_mode = 0;
    repeat (4) step();

    // Reset during FALL, then resume with all requesters pending.
    add_word(1, W'($urandom));
    load_batch(1'b0);
    drive();
    n = 0;
    seen = 1'b0;
    while (n < 60) begin
      step();
      n++;
      if (ch_req) seen = 1'b1;
      if (seen && busy && !ch_req) break;
    end
    if (n >= 60) fail("reach_fall_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ch_req", ch_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_done", req_done, 0);
    flush();
    drive();
    repeat (3) step();
    rst_n = 1'b1;
    add_word(0, W'($urandom));
    add_word(1, W'($urandom));
    add_word(2, W'($urandom));
    add_word(3, W'($urandom));
    add_word(0, W'($urandom));
    load_batch(1'b0);
    drive();
    drain(400);

    // Stale ack held high across reset release.
    ack_mode = 1;
    step();
    rst_n = 1'b0;
    flush();
    drive();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (SS + 2) step();
    add_word(1, W'($urandom));
    load_batch(1'b0);
    drive();
    repeat (8) begin
      step();
      chk("stale_no_req", ch_req, 0);
    end
    ack_mode = 0;
    n = 0;
    while (!ch_req && n < 20) begin step(); n++; end
    chk("stale_release_latency", n, SS + 1);
    drain(200);

    // Random batches.
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < N; i++) begin
        n = $urandom_range(0, 2);
        for (int j = 0; j < n; j++) add_word(i, W'($urandom));
      end
      load_batch(1'b0);
      drive();
      drain(800);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
